alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 64 ++++++
 rtl/alu.sv | 42 ++++
 tb/tb_alu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and opcode width.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_PASSA = 4'd11,
    OP_PASSB = 4'd12,
    OP_NAND = 4'd13,
    OP_XNOR = 4'd14,
    OP_NOTA = 4'd15
  } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU data path: result, zero flag and signed-overflow flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] r,
  output logic            z,
  output logic            v
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [SHW-1:0]  sh;
  logic            slt;
  logic            sltu;

  assign sum  = a + b;
  assign diff = a - b;
  assign sh   = b[SHW-1:0];
  assign slt  = $signed(a) < $signed(b);
  assign sltu = a < b;

  always_comb begin
    r = '0;
    v = 1'b0;
    case (alu_op_t'(op))
      OP_ADD: begin
        r = sum;
        v = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        r = diff;
        v = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOR:   r = ~(a | b);
      OP_SLL:   r = a << sh;
      OP_SRL:   r = a >> sh;
      OP_SRA:   r = XLEN'($signed(a) >>> sh);
      OP_SLT:   r = {{(XLEN-1){1'b0}}, slt};
      OP_SLTU:  r = {{(XLEN-1){1'b0}}, sltu};
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      OP_NAND:  r = ~(a & b);
      OP_XNOR:  r = ~(a ^ b);
      OP_NOTA:  r = ~a;
      default: begin
        r = '0;
        v = 1'b0;
      end
    endcase
  end

  assign z = (r == '0);

endmodule

// File: rtl/alu.sv
// ALU top: combinational core plus a one-cycle registered copy of its outputs.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] r,
  output logic            z,
  output logic            v,
  output logic [XLEN-1:0] r_q,
  output logic            z_q,
  output logic            v_q
);

  alu_core #(.XLEN(XLEN)) u_core (
    .a  (a),
    .b  (b),
    .op (op),
    .r  (r),
    .z  (z),
    .v  (v)
  );

  // Synchronous reset wins over capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      r_q <= r;
      z_q <= z;
      v_q <= v;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector and sweep bench for the alu block at XLEN=32.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] r;
  logic        z;
  logic        v;
  logic [31:0] r_q;
  logic        z_q;
  logic        v_q;

  int n_cmp;
  int n_bad;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs [13];

  alu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .r     (r),
    .z     (z),
    .v     (v),
    .r_q   (r_q),
    .z_q   (z_q),
    .v_q   (v_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent reference using 64-bit signed arithmetic.
  function automatic void model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] mr, output logic mv);
    longint sa, sb, s;
    int     sh;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sh = int'(mb & 32'd31);
    mv = 1'b0;
    case (mop)
      4'd0: begin s = sa + sb; mr = s[31:0]; mv = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; mr = s[31:0]; mv = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2:  mr = ma & mb;
      4'd3:  mr = ma | mb;
      4'd4:  mr = ma ^ mb;
      4'd5:  mr = ~(ma | mb);
      4'd6:  begin s = longint'({32'd0, ma}) << sh; mr = s[31:0]; end
      4'd7:  begin s = longint'({32'd0, ma}) >> sh; mr = s[31:0]; end
      4'd8:  begin s = sa >>> sh; mr = s[31:0]; end
      4'd9:  mr = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: mr = ({32'd0, ma} < {32'd0, mb}) ? 32'd1 : 32'd0;
      4'd11: mr = ma;
      4'd12: mr = mb;
      4'd13: mr = ~(ma & mb);
      4'd14: mr = ~(ma ^ mb);
      default: mr = ~ma;
    endcase
  endfunction

  initial begin
    logic [31:0] er;
    logic        ev;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    a  = '0;
    b  = '0;
    op = '0;

    vecs[0]  = '{"add_zero",  4'd0,  32'hFFFFFFFC, 32'h4,        32'h0,        1'b1, 1'b0};
    vecs[1]  = '{"add_ovf",   4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1};
    vecs[2]  = '{"sub_ovf",   4'd1,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3]  = '{"sub_zero",  4'd1,  32'h3,        32'h3,        32'h0,        1'b1, 1'b0};
    vecs[4]  = '{"srl",       4'd7,  32'hF0000000, 32'h4,        32'h0F000000, 1'b0, 1'b0};
    vecs[5]  = '{"sra",       4'd8,  32'hF0000000, 32'h4,        32'hFF000000, 1'b0, 1'b0};
    vecs[6]  = '{"sll_out",   4'd6,  32'hF0000000, 32'h4,        32'h0,        1'b1, 1'b0};
    vecs[7]  = '{"sll_mask",  4'd6,  32'h00000001, 32'h24,       32'h10,       1'b0, 1'b0};
    vecs[8]  = '{"slt",       4'd9,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0};
    vecs[9]  = '{"sltu",      4'd10, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
    vecs[10] = '{"sra_by0",   4'd8,  32'h80000001, 32'h20,       32'h80000001, 1'b0, 1'b0};
    vecs[11] = '{"nota_zero", 4'd15, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[12] = '{"nor",       4'd5,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};

    // Register stage: reset, capture, mid-stream reset, resume.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_r_q", r_q, 32'h0);
    check("rst_z_q", 32'(z_q), 32'h0);
    check("rst_v_q", 32'(v_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op = 4'd0; a = 32'd2; b = 32'd3;
    #1;
    check("comb_r", r, 32'd5);
    check("comb_r_q_not_yet", r_q, 32'h0);
    @(posedge clk);
    #1;
    check("cap_r_q", r_q, 32'd5);
    check("cap_z_q", 32'(z_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("r_during_rst", r, 32'd5);
    @(posedge clk);
    #1;
    check("midrst_r_q", r_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_r_q", r_q, 32'd5);
    @(negedge clk);
    a = 32'h7FFFFFFF; b = 32'd1;
    @(posedge clk);
    #1;
    check("ovf_r_q", r_q, 32'h80000000);
    check("ovf_v_q", 32'(v_q), 32'h1);
    @(negedge clk);
    a = 32'd3; b = 32'hFFFFFFFD;
    @(posedge clk);
    #1;
    check("zero_z_q", 32'(z_q), 32'h1);

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1;
      check({vecs[i].name, "_r"}, r, vecs[i].r);
      check({vecs[i].name, "_z"}, 32'(z), 32'(vecs[i].z));
      check({vecs[i].name, "_v"}, 32'(v), 32'(vecs[i].v));
    end

    // Sweep all ops over small signed operands.
    for (int o = 0; o < 16; o++) begin
      for (int ia = -4; ia <= 3; ia++) begin
        for (int ib = -4; ib <= 3; ib++) begin
          op = 4'(o); a = 32'(ia); b = 32'(ib);
          #1;
          model(op, a, b, er, ev);
          check($sformatf("sweep_r op%0d a%0d b%0d", o, ia, ib), r, er);
          check($sformatf("sweep_z op%0d a%0d b%0d", o, ia, ib), 32'(z), (er == 32'h0) ? 32'h1 : 32'h0);
          check($sformatf("sweep_v op%0d a%0d b%0d", o, ia, ib), 32'(v), 32'(ev));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
